ann_frame_streamer: RTL and testbench
=====================================

// Module: ann_frame_streamer
// PURPOSE
//  Front-end frame buffer for the ANN->SNN accelerator. Captures one input frame from a byte-wide write port.
//  Replays it pixel by pixel over the 4-phase req/ack data handshake into the ANN engine input.
//  Then pulses the SNN accelerator start and waits for its done before accepting the next frame.
// PARAMETERS
//  DATA_W     8   bits per channel sample (Q1.7)
//  C1_IN_CH   4   channels per pixel; output word = C1_IN_CH*DATA_W bits
//  IMG_W      9   frame width in pixels
//  IMG_H      8   frame height in pixels
//  (localparam NUM_PIX = IMG_W*IMG_H = 72; pixel counter width = $clog2(NUM_PIX))
// PORTS
//  clk                   in   1                  single clock, all logic rising-edge
//  rst                   in   1                  asynchronous reset, active-high
//  i_wr_valid            in   1                  write strobe for i_wr_data
//  i_wr_data             in   DATA_W             sample; order pixel-major (raster), channel 0..C1_IN_CH-1 within pixel
//  o_wr_ready            out  1                  high only in LOAD; writes with ready low are dropped
//  o_data_req            out  1                  4-phase request to ANN engine
//  o_data_flat           out  C1_IN_CH*DATA_W    pixel word; channel c at [c*DATA_W +: DATA_W]
//  i_data_ack            in   1                  4-phase acknowledge from ANN engine
//  o_accelerator_start   out  1                  1-cycle start pulse to SNN engine
//  i_accelerator_done    in   1                  SNN completion (level or pulse)
//  o_frame_done          out  1                  1-cycle pulse when frame fully processed
//  o_busy                out  1                  high in every state except LOAD
// BEHAVIOUR
//  Reset: state=LOAD, counters=0, o_wr_ready=1 (combinational from state), all other outputs 0.
//  Reset mid-frame: abandons frame; partially written data discarded.
//  Storage: NUM_PIX x (C1_IN_CH*DATA_W) array. Channel bytes are assembled in a pack register.
//   The word is written on the last channel byte of each pixel.
//  States:
//   LOAD:     accept i_wr_valid bytes; ch_cnt wraps at C1_IN_CH-1, then pix_cnt++.
//             Write of channel C1_IN_CH-1 of pixel NUM_PIX-1 -> FETCH, pix_cnt=0, ch_cnt=0.
//             i_data_ack / i_accelerator_done ignored.
//   FETCH:    read array[pix_cnt] into o_data_flat register -> REQ (1 cycle).
//   REQ:      o_data_req=1; o_data_flat held stable while req high.
//             On sampled i_data_ack=1 drop req next cycle -> ACK_LO.
//   ACK_LO:   req=0; wait i_data_ack=0. Then:
//             if pix_cnt==NUM_PIX-1 -> START;
//             else pix_cnt++ -> FETCH.
//   START:    o_accelerator_start=1 for exactly one cycle -> WAIT_DONE.
//   WAIT_DONE: i_accelerator_done sampled starting the cycle after START.
//             On 1: o_frame_done pulse one cycle, counters cleared -> LOAD.
//  Latency: last write -> first req = 2 cycles.
//   Each pixel costs >= 4 cycles (FETCH, REQ, ACK_LO min 1, + ack round trip).
//  Handshake rules:
//   - req never rises while ack is high (ACK_LO guards this).
//   - ack high before req is ignored.
//   - ack held high indefinitely stalls in ACK_LO with req=0.
//  Done asserted in the START cycle is ignored (stale); only WAIT_DONE samples count.
//  No arithmetic on data; samples pass bit-exact, signed Q1.7 untouched.
// TESTING
//  1. Reset then write 288 bytes b=(p*4+c)&0xFF, ack responder 1-cycle delay
//     -> 72 req cycles; pixel 5 word = 0x17161514; one start pulse; done -> o_frame_done, o_wr_ready=1.
//  2. i_wr_valid pulses while o_busy=1 (e.g. during pixel 10)
//     -> bytes dropped; next frame's pixel 0 still takes first byte written in LOAD.
//  3. Slow ack: ack rises 7 cycles after req, falls 5 cycles after req drop
//     -> o_data_flat constant throughout; no new req until ack=0.
//  4. Hold i_accelerator_done=1 continuously from before START
//     -> frame_done exactly 1 cycle after WAIT_DONE entered, single pulse; i_data_ack high in LOAD has no effect.
//  5. Assert rst at pixel 40 with req high
//     -> req/start/frame_done drop asynchronously; o_wr_ready=1; next full frame streams from pixel 0 correctly.
//  6. Back-to-back frames with bytes 0x80 (−1.0) and 0x7F
//     -> words 0x80808080 / 0x7F7F7F7F bit-exact; exactly one start per frame.

Source files
------------

// File: rtl/ann_frame_streamer_if.sv
// Bundles the frame-streamer handshake signals: byte write port, 4-phase pixel
// handshake to the ANN engine, SNN start/done and status.
interface ann_frame_streamer_if #(
  parameter int DATA_W   = 8,
  parameter int C1_IN_CH = 4
);
  logic                         i_wr_valid;
  logic [DATA_W-1:0]            i_wr_data;
  logic                         o_wr_ready;
  logic                         o_data_req;
  logic [C1_IN_CH*DATA_W-1:0]   o_data_flat;
  logic                         i_data_ack;
  logic                         o_accelerator_start;
  logic                         i_accelerator_done;
  logic                         o_frame_done;
  logic                         o_busy;

  modport master (
    output i_wr_valid, i_wr_data, i_data_ack, i_accelerator_done,
    input  o_wr_ready, o_data_req, o_data_flat, o_accelerator_start,
           o_frame_done, o_busy
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_data_ack, i_accelerator_done,
    output o_wr_ready, o_data_req, o_data_flat, o_accelerator_start,
           o_frame_done, o_busy
  );
endinterface

// File: rtl/ann_frame_streamer.sv
// Frame buffer for the ANN->SNN accelerator: captures one frame of bytes, replays
// it pixel by pixel over a 4-phase req/ack handshake, then starts the SNN engine.
//
//  state       | meaning
//  S_LOAD      | accept channel bytes into the frame buffer
//  S_FETCH     | read the current pixel word into the output register
//  S_REQ       | req high, word stable, waiting for ack
//  S_ACK_LO    | req low, waiting for ack to return low
//  S_START     | one-cycle start pulse to the SNN engine
//  S_WAIT_DONE | waiting for SNN completion
module ann_frame_streamer #(
  parameter int DATA_W   = 8,
  parameter int C1_IN_CH = 4,
  parameter int IMG_W    = 9,
  parameter int IMG_H    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  ann_frame_streamer_if.slave   bus
);

  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int WORD_W  = C1_IN_CH * DATA_W;
  localparam int PIX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int CH_W    = (C1_IN_CH > 1) ? $clog2(C1_IN_CH) : 1;

  typedef enum logic [2:0] {
    S_LOAD      = 3'd0,
    S_FETCH     = 3'd1,
    S_REQ       = 3'd2,
    S_ACK_LO    = 3'd3,
    S_START     = 3'd4,
    S_WAIT_DONE = 3'd5
  } state_t;

  state_t              state_q;
  logic [PIX_W-1:0]    pix_q;
  logic [CH_W-1:0]     ch_q;
  logic [WORD_W-1:0]   pack_q;
  logic [WORD_W-1:0]   pack_d;
  logic [WORD_W-1:0]   data_q;
  logic                req_q;
  logic                start_q;
  logic                fdone_q;
  logic [WORD_W-1:0]   frame_mem_q [NUM_PIX];

  logic wr_fire;
  logic last_ch;
  logic last_pix;

  assign wr_fire  = bus.i_wr_valid && (state_q == S_LOAD);
  assign last_ch  = (ch_q == CH_W'(C1_IN_CH - 1));
  assign last_pix = (pix_q == PIX_W'(NUM_PIX - 1));

  // The incoming byte is merged here so the last channel lands in the same write.
  always_comb begin
    pack_d = pack_q;
    pack_d[int'(ch_q)*DATA_W +: DATA_W] = bus.i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (wr_fire && last_ch) begin
      frame_mem_q[pix_q] <= pack_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      pix_q   <= '0;
      ch_q    <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      start_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      fdone_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (bus.i_wr_valid) begin
            pack_q <= pack_d;
            if (last_ch) begin
              ch_q <= '0;
              if (last_pix) begin
                pix_q   <= '0;
                state_q <= S_FETCH;
              end else begin
                pix_q <= pix_q + PIX_W'(1);
              end
            end else begin
              ch_q <= ch_q + CH_W'(1);
            end
          end
        end
        S_FETCH: begin
          data_q  <= frame_mem_q[pix_q];
          req_q   <= 1'b1;
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (bus.i_data_ack) begin
            req_q   <= 1'b0;
            state_q <= S_ACK_LO;
          end
        end
        // Holding here until ack is low keeps req from rising over a stale ack.
        S_ACK_LO: begin
          if (!bus.i_data_ack) begin
            if (last_pix) begin
              start_q <= 1'b1;
              state_q <= S_START;
            end else begin
              pix_q   <= pix_q + PIX_W'(1);
              state_q <= S_FETCH;
            end
          end
        end
        S_START: begin
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.i_accelerator_done) begin
            fdone_q <= 1'b1;
            pix_q   <= '0;
            ch_q    <= '0;
            state_q <= S_LOAD;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.o_wr_ready          = (state_q == S_LOAD);
  assign bus.o_busy              = (state_q != S_LOAD);
  assign bus.o_data_req          = req_q;
  assign bus.o_data_flat         = data_q;
  assign bus.o_accelerator_start = start_q;
  assign bus.o_frame_done        = fdone_q;

endmodule

// File: tb/tb_ann_frame_streamer.sv
// Directed-plus-random bench for ann_frame_streamer: frames are built as byte
// arrays and each streamed pixel is compared with the word assembled from them.
module tb_ann_frame_streamer;

  localparam int DATA_W = 8;
  localparam int CH     = 4;
  localparam int IMG_W  = 9;
  localparam int IMG_H  = 8;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NB     = NPIX * CH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ann_frame_streamer_if #(.DATA_W(DATA_W), .C1_IN_CH(CH)) bus ();

  ann_frame_streamer #(
    .DATA_W(DATA_W), .C1_IN_CH(CH), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_fdone  = 0;
  int exp_starts = 0;
  int exp_fdone  = 0;

  logic [7:0]  frame_b [NB];
  logic [31:0] got     [NPIX];

  always @(negedge clk) begin
    if (bus.o_accelerator_start === 1'b1) n_starts++;
    if (bus.o_frame_done === 1'b1) n_fdone++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int p);
    logic [31:0] w;
    for (int c = 0; c < CH; c++) w[c*8 +: 8] = frame_b[p*CH + c];
    return w;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < NB; i++) begin
      case (mode)
        0:       frame_b[i] = 8'(i);
        1:       frame_b[i] = 8'($urandom);
        2:       frame_b[i] = 8'h80;
        default: frame_b[i] = 8'h7F;
      endcase
    end
  endtask

  task automatic write_frame();
    bit rdy_ok = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.i_wr_valid = 1'b0;
        @(negedge clk);
      end
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = frame_b[i];
      if (bus.o_wr_ready !== 1'b1 || bus.o_busy !== 1'b0) rdy_ok = 1'b0;
      @(negedge clk);
    end
    bus.i_wr_valid = 1'b0;
    check("load_ready", rdy_ok, 1'b1);
    check("fetch_cycle", {bus.o_data_req, bus.o_wr_ready, bus.o_busy}, 3'b001);
    @(negedge clk);
    check("first_req_latency", bus.o_data_req, 1'b1);
  endtask

  task automatic stream(input int rise, input int fall, input int abort_pix, output bit aborted);
    aborted = 1'b0;
    for (int p = 0; p < NPIX; p++) begin
      int t;
      logic [31:0] w;
      bit hold_ok;
      bit low_ok;
      t = 0;
      while (bus.o_data_req !== 1'b1 && t < 40) begin
        @(negedge clk);
        t++;
      end
      check("req_rise", bus.o_data_req, 1'b1);
      if (bus.o_data_req !== 1'b1) begin
        aborted = 1'b1;
        return;
      end
      w = bus.o_data_flat;
      got[p] = w;
      check("pix_word", w, exp_word(p));
      if (p == abort_pix) begin
        #2 rst = 1'b1;
        #1 check("rst_async_outputs",
                 {bus.o_data_req, bus.o_accelerator_start, bus.o_frame_done,
                  bus.o_wr_ready, bus.o_busy}, 5'b00010);
        aborted = 1'b1;
        return;
      end
      if (p == 10) begin
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = 8'hEE;
      end
      hold_ok = 1'b1;
      for (int i = 1; i < rise; i++) begin
        @(negedge clk);
        if (bus.o_data_flat !== w || bus.o_data_req !== 1'b1) hold_ok = 1'b0;
      end
      bus.i_data_ack = 1'b1;
      t = 0;
      @(negedge clk);
      while (bus.o_data_req === 1'b1 && t < 40) begin
        if (bus.o_data_flat !== w) hold_ok = 1'b0;
        @(negedge clk);
        t++;
      end
      check("req_hold_stable", hold_ok, 1'b1);
      check("req_fall", bus.o_data_req, 1'b0);
      low_ok = 1'b1;
      for (int i = 1; i < fall; i++) begin
        @(negedge clk);
        if (bus.o_data_req !== 1'b0) low_ok = 1'b0;
      end
      check("req_low_while_ack", low_ok, 1'b1);
      bus.i_data_ack = 1'b0;
      bus.i_wr_valid = 1'b0;
    end
  endtask

  task automatic finish_frame(input bit hold);
    if (hold) bus.i_accelerator_done = 1'b1;
    @(negedge clk);
    check("start_pulse", {bus.o_accelerator_start, bus.o_frame_done, bus.o_busy}, 3'b101);
    @(negedge clk);
    check("start_one_cycle", {bus.o_accelerator_start, bus.o_frame_done, bus.o_busy}, 3'b001);
    exp_starts++;
    check("start_count", n_starts, exp_starts);
    if (hold) begin
      bit idle_ok = 1'b1;
      @(negedge clk);
      check("frame_done_held", {bus.o_frame_done, bus.o_wr_ready, bus.o_busy}, 3'b110);
      bus.i_data_ack = 1'b1;
      @(negedge clk);
      check("frame_done_single", bus.o_frame_done, 1'b0);
      repeat (4) begin
        @(negedge clk);
        if (bus.o_data_req !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_frame_done !== 1'b0)
          idle_ok = 1'b0;
      end
      check("ack_ignored_in_load", idle_ok, 1'b1);
      bus.i_data_ack         = 1'b0;
      bus.i_accelerator_done = 1'b0;
    end else begin
      bit wait_ok = 1'b1;
      int d = $urandom_range(1, 4);
      repeat (d) begin
        @(negedge clk);
        if (bus.o_frame_done !== 1'b0 || bus.o_busy !== 1'b1) wait_ok = 1'b0;
      end
      check("wait_done_idle", wait_ok, 1'b1);
      bus.i_accelerator_done = 1'b1;
      @(negedge clk);
      bus.i_accelerator_done = 1'b0;
      check("frame_done_pulse", {bus.o_frame_done, bus.o_wr_ready, bus.o_busy}, 3'b110);
      @(negedge clk);
      check("frame_done_single", bus.o_frame_done, 1'b0);
    end
    exp_fdone++;
    check("frame_done_count", n_fdone, exp_fdone);
    check("start_count_after", n_starts, exp_starts);
  endtask

  initial begin
    bit ab;
    rst                    = 1'b1;
    bus.i_wr_valid         = 1'b0;
    bus.i_wr_data          = '0;
    bus.i_data_ack         = 1'b0;
    bus.i_accelerator_done = 1'b0;
    #1;
    check("reset_state",
          {bus.o_data_req, bus.o_accelerator_start, bus.o_frame_done,
           bus.o_wr_ready, bus.o_busy, bus.o_data_flat}, {5'b00010, 32'h0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {bus.o_wr_ready, bus.o_busy, bus.o_data_req}, 3'b100);

    // Frame A: ramp pattern, fast ack, writes attempted while busy at pixel 10.
    fill(0);
    write_frame();
    stream(1, 1, -1, ab);
    finish_frame(1'b0);
    check("pixel5_word", got[5], 32'h17161514);

    // Frame B: random data, slow ack, done held from before start.
    fill(1);
    write_frame();
    stream(7, 5, -1, ab);
    finish_frame(1'b1);

    // Frame C: reset while pixel 40 is requested.
    fill(1);
    write_frame();
    stream(2, 2, 40, ab);
    @(negedge clk);
    rst            = 1'b0;
    bus.i_data_ack = 1'b0;
    bus.i_wr_valid = 1'b0;
    @(negedge clk);
    check("after_abort_idle",
          {bus.o_wr_ready, bus.o_busy, bus.o_data_req, bus.o_accelerator_start}, 4'b1000);
    check("abort_no_start", n_starts, exp_starts);

    // Frame D: full frame after abort, mixed ack timing.
    fill(1);
    write_frame();
    stream(2, 3, -1, ab);
    finish_frame(1'b0);

    // Frames E/F: extreme Q1.7 values back to back.
    fill(2);
    write_frame();
    stream(1, 1, -1, ab);
    finish_frame(1'b0);
    check("word_neg_one", got[NPIX-1], 32'h80808080);

    fill(3);
    write_frame();
    stream(1, 2, -1, ab);
    finish_frame(1'b1);
    check("word_max_pos", got[0], 32'h7F7F7F7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
